// File: rtl/door_ctrl_fsm.sv
// +----------------------------------------------------------------------------+
// | door_ctrl_fsm : elevator door controller with timed strokes, obstruction    |
// |                 reopen, reopen limit with nudge mode and motion interlock.  |
// | Revision      : 1.0                                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module door_ctrl_fsm #(
  parameter int FLOORS        = 4,
  parameter int FLOOR_W       = 2,
  parameter int HOLD_CYCLES   = 100000000,
  parameter int TRAVEL_CYCLES = 25000000,
  parameter int MAX_REOPEN    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arrive,
  input  logic               car_moving,
  input  logic [FLOOR_W-1:0] cur_floor,
  input  logic               open_btn,
  input  logic               close_btn,
  input  logic               obstruct,
  output logic [1:0]         door_state,
  output logic               door_closed,
  output logic               req_clear,
  output logic [FLOOR_W-1:0] served_floor,
  output logic               nudge
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > TRAVEL_CYCLES) ? HOLD_CYCLES : TRAVEL_CYCLES;
  localparam int TIMER_W    = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam int CNT_W      = $clog2(MAX_REOPEN + 1);

  localparam logic [TIMER_W-1:0] TRAVEL_LAST = TIMER_W'(TRAVEL_CYCLES - 1);
  localparam logic [TIMER_W-1:0] HOLD_LAST   = TIMER_W'(HOLD_CYCLES - 1);
  localparam logic [TIMER_W-1:0] TIMER_SAT   = {TIMER_W{1'b1}};
  localparam logic [CNT_W-1:0]   REOPEN_MAX  = CNT_W'(MAX_REOPEN);
  localparam logic [FLOOR_W:0]   FLOOR_LIM   = (FLOOR_W + 1)'(FLOORS);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'b00,
    ST_OPENING = 2'b01,
    ST_OPEN    = 2'b10,
    ST_CLOSING = 2'b11
  } state_t;

  state_t               state_q, state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]     reopen_cnt_q, reopen_cnt_d;
  logic                 nudge_q, nudge_d;
  logic                 req_clear_q, req_clear_d;
  logic                 door_closed_q, door_closed_d;
  logic [FLOOR_W-1:0]   served_floor_q, served_floor_d;

  logic                 open_req;
  logic                 floor_ok;
  logic                 hold_open;
  logic                 reverse;
  logic [TIMER_W-1:0]   timer_inc;
  logic [CNT_W-1:0]     reopen_inc;

  assign open_req   = arrive | (open_btn & ~car_moving);
  // An out-of-range floor index still opens the door but is never latched.
  assign floor_ok   = ({1'b0, cur_floor} < FLOOR_LIM);
  assign hold_open  = ~nudge_q & (open_btn | obstruct);
  assign reverse    = ~nudge_q & (obstruct | open_btn | arrive);
  assign timer_inc  = (timer_q == TIMER_SAT) ? timer_q : timer_q + TIMER_W'(1);
  assign reopen_inc = (reopen_cnt_q == REOPEN_MAX) ? reopen_cnt_q : reopen_cnt_q + CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    reopen_cnt_d   = reopen_cnt_q;
    nudge_d        = nudge_q;
    served_floor_d = served_floor_q;
    req_clear_d    = 1'b0;
    door_closed_d  = (state_q == ST_CLOSED);

    case (state_q)
      ST_CLOSED: begin
        if (open_req && !car_moving) begin
          state_d = ST_OPENING;
          timer_d = '0;
          if (arrive && floor_ok) begin
            served_floor_d = cur_floor;
          end
        end
      end

      ST_OPENING: begin
        if (timer_q == TRAVEL_LAST) begin
          state_d     = ST_OPEN;
          timer_d     = '0;
          req_clear_d = 1'b1;
        end else begin
          timer_d = timer_inc;
        end
      end

      ST_OPEN: begin
        if (hold_open) begin
          timer_d = '0;
        end else if (close_btn || (timer_q == HOLD_LAST)) begin
          state_d = ST_CLOSING;
          timer_d = '0;
        end else begin
          timer_d = timer_inc;
        end
      end

      ST_CLOSING: begin
        // Reversal wins over stroke completion; the reopen stroke covers
        // exactly the distance already travelled towards closed.
        if (reverse) begin
          state_d      = ST_OPENING;
          timer_d      = TRAVEL_LAST - timer_q;
          reopen_cnt_d = reopen_inc;
          nudge_d      = (reopen_inc == REOPEN_MAX);
        end else if (timer_q == TRAVEL_LAST) begin
          state_d      = ST_CLOSED;
          timer_d      = '0;
          reopen_cnt_d = '0;
          nudge_d      = 1'b0;
        end else begin
          timer_d = timer_inc;
        end
      end

      default: begin
        state_d = ST_CLOSED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_CLOSED;
      timer_q        <= '0;
      reopen_cnt_q   <= '0;
      nudge_q        <= 1'b0;
      req_clear_q    <= 1'b0;
      door_closed_q  <= 1'b1;
      served_floor_q <= '0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      reopen_cnt_q   <= reopen_cnt_d;
      nudge_q        <= nudge_d;
      req_clear_q    <= req_clear_d;
      door_closed_q  <= door_closed_d;
      served_floor_q <= served_floor_d;
    end
  end

  assign door_state   = state_q;
  assign door_closed  = door_closed_q;
  assign req_clear    = req_clear_q;
  assign served_floor = served_floor_q;
  assign nudge        = nudge_q;

endmodule

`default_nettype wire

// File: tb/tb_door_ctrl_fsm.sv
// +----------------------------------------------------------------------------+
// | tb_door_ctrl_fsm : directed bench for door_ctrl_fsm (HOLD=10, TRAVEL=4,     |
// |                    MAX_REOPEN=2).  Revision 1.0                             |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module tb_door_ctrl_fsm;

  logic       clk;
  logic       rst_n;
  logic       arrive;
  logic       car_moving;
  logic [1:0] cur_floor;
  logic       open_btn;
  logic       close_btn;
  logic       obstruct;
  logic [1:0] door_state;
  logic       door_closed;
  logic       req_clear;
  logic [1:0] served_floor;
  logic       nudge;

  int checks = 0;
  int errors = 0;

  door_ctrl_fsm #(
    .FLOORS(4), .FLOOR_W(2), .HOLD_CYCLES(10), .TRAVEL_CYCLES(4), .MAX_REOPEN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .arrive(arrive), .car_moving(car_moving),
    .cur_floor(cur_floor), .open_btn(open_btn), .close_btn(close_btn),
    .obstruct(obstruct), .door_state(door_state), .door_closed(door_closed),
    .req_clear(req_clear), .served_floor(served_floor), .nudge(nudge)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are read 1 ns after the edge; inputs changed there are seen at the next edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", door_state); end
    checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL reset_door_closed: got %0b want 1", door_closed); end
    checks++; if (req_clear !== 1'b0) begin errors++; $display("FAIL reset_req_clear: got %0b want 0", req_clear); end
    checks++; if (served_floor !== 2'd0) begin errors++; $display("FAIL reset_served_floor: got %0d want 0", served_floor); end
    checks++; if (nudge !== 1'b0) begin errors++; $display("FAIL reset_nudge: got %0b want 0", nudge); end
    rst_n = 1'b1;
    step(1);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL reset_idle: got %0d want 0", door_state); end
  endtask

  task automatic test_normal_cycle();
    cur_floor = 2'd2; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL arrive_opening: got %0d want 1", door_state); end
    checks++; if (served_floor !== 2'd2) begin errors++; $display("FAIL arrive_served: got %0d want 2", served_floor); end
    checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL closed_lag: got %0b want 1", door_closed); end
    step(1);
    checks++; if (door_closed !== 1'b0) begin errors++; $display("FAIL closed_drop: got %0b want 0", door_closed); end
    step(2);
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL opening_t3: got %0d want 1", door_state); end
    checks++; if (req_clear !== 1'b0) begin errors++; $display("FAIL req_clear_early: got %0b want 0", req_clear); end
    step(1);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL open_entry: got %0d want 2", door_state); end
    checks++; if (req_clear !== 1'b1) begin errors++; $display("FAIL req_clear_pulse: got %0b want 1", req_clear); end
    step(1);
    checks++; if (req_clear !== 1'b0) begin errors++; $display("FAIL req_clear_width: got %0b want 0", req_clear); end
    step(8);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL hold_last: got %0d want 2", door_state); end
    step(1);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL hold_expire: got %0d want 3", door_state); end
    step(3);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL closing_t3: got %0d want 3", door_state); end
    step(1);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL closed_entry: got %0d want 0", door_state); end
    checks++; if (door_closed !== 1'b0) begin errors++; $display("FAIL closed_rise_lag: got %0b want 0", door_closed); end
    step(1);
    checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL closed_rise: got %0b want 1", door_closed); end
  endtask

  task automatic test_reset_mid_open();
    cur_floor = 2'd1; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    step(4);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL rst_pre_open: got %0d want 2", door_state); end
    step(2);
    rst_n = 1'b0;
    step(1);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL rst_mid_state: got %0d want 0", door_state); end
    checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL rst_mid_closed: got %0b want 1", door_closed); end
    checks++; if (nudge !== 1'b0) begin errors++; $display("FAIL rst_mid_nudge: got %0b want 0", nudge); end
    checks++; if (served_floor !== 2'd0) begin errors++; $display("FAIL rst_mid_served: got %0d want 0", served_floor); end
    step(1);
    rst_n = 1'b1;
    step(1);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL rst_mid_release: got %0d want 0", door_state); end
  endtask

  task automatic test_car_moving();
    open_btn = 1'b1; car_moving = 1'b1;
    step(3);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL interlock_state: got %0d want 0", door_state); end
    checks++; if (door_closed !== 1'b1) begin errors++; $display("FAIL interlock_closed: got %0b want 1", door_closed); end
    car_moving = 1'b0;
    step(1);
    open_btn = 1'b0;
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL interlock_release: got %0d want 1", door_state); end
    checks++; if (served_floor !== 2'd0) begin errors++; $display("FAIL btn_no_latch: got %0d want 0", served_floor); end
    step(4);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL btn_open: got %0d want 2", door_state); end
  endtask

  task automatic test_close_btn();
    step(3);
    close_btn = 1'b1;
    step(1);
    close_btn = 1'b0;
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL close_btn: got %0d want 3", door_state); end
    step(4);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL close_btn_done: got %0d want 0", door_state); end
    cur_floor = 2'd1; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    step(4);
    step(3);
    close_btn = 1'b1; open_btn = 1'b1;
    step(1);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL open_wins: got %0d want 2", door_state); end
    step(2);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL open_wins_hold: got %0d want 2", door_state); end
    close_btn = 1'b0; open_btn = 1'b0;
    step(9);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL open_wins_timer: got %0d want 2", door_state); end
    step(1);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL open_wins_close: got %0d want 3", door_state); end
    step(4);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL open_wins_done: got %0d want 0", door_state); end
  endtask

  task automatic test_obstruct_reopen();
    cur_floor = 2'd3; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    step(14);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL reopen_closing: got %0d want 3", door_state); end
    step(1);
    obstruct = 1'b1;
    step(1);
    obstruct = 1'b0;
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL reopen1_state: got %0d want 1", door_state); end
    checks++; if (nudge !== 1'b0) begin errors++; $display("FAIL reopen1_nudge: got %0b want 0", nudge); end
    step(1);
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL reopen1_stroke: got %0d want 1", door_state); end
    step(1);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL reopen1_open: got %0d want 2", door_state); end
    checks++; if (req_clear !== 1'b1) begin errors++; $display("FAIL reopen1_req_clear: got %0b want 1", req_clear); end
    step(10);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL reopen2_closing: got %0d want 3", door_state); end
    obstruct = 1'b1;
    step(1);
    obstruct = 1'b0;
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL reopen2_state: got %0d want 1", door_state); end
    checks++; if (nudge !== 1'b1) begin errors++; $display("FAIL reopen2_nudge: got %0b want 1", nudge); end
    step(1);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL reopen2_open: got %0d want 2", door_state); end
    obstruct = 1'b1;
    step(9);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL nudge_open_hold: got %0d want 2", door_state); end
    step(1);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL nudge_open_ignore: got %0d want 3", door_state); end
    step(3);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL nudge_no_reverse: got %0d want 3", door_state); end
    checks++; if (nudge !== 1'b1) begin errors++; $display("FAIL nudge_held: got %0b want 1", nudge); end
    step(1);
    obstruct = 1'b0;
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL nudge_closed: got %0d want 0", door_state); end
    checks++; if (nudge !== 1'b0) begin errors++; $display("FAIL nudge_cleared: got %0b want 0", nudge); end
    checks++; if (served_floor !== 2'd3) begin errors++; $display("FAIL reopen_served: got %0d want 3", served_floor); end
  endtask

  task automatic test_obstruct_hold();
    cur_floor = 2'd1; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    step(4);
    obstruct = 1'b1; cur_floor = 2'd2; arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL arrive_absorbed: got %0d want 2", door_state); end
    checks++; if (served_floor !== 2'd1) begin errors++; $display("FAIL arrive_absorbed_floor: got %0d want 1", served_floor); end
    step(14);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL obstruct_hold: got %0d want 2", door_state); end
    obstruct = 1'b0;
    step(9);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL obstruct_release_t9: got %0d want 2", door_state); end
    step(1);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL obstruct_release_close: got %0d want 3", door_state); end
    arrive = 1'b1;
    step(1);
    arrive = 1'b0;
    checks++; if (door_state !== 2'd1) begin errors++; $display("FAIL arrive_reverse: got %0d want 1", door_state); end
    step(1);
    checks++; if (door_state !== 2'd2) begin errors++; $display("FAIL arrive_reverse_open: got %0d want 2", door_state); end
    step(10);
    checks++; if (door_state !== 2'd3) begin errors++; $display("FAIL back_closing: got %0d want 3", door_state); end
    step(4);
    checks++; if (door_state !== 2'd0) begin errors++; $display("FAIL back_closed: got %0d want 0", door_state); end
    checks++; if (nudge !== 1'b0) begin errors++; $display("FAIL back_nudge: got %0b want 0", nudge); end
  endtask

  initial begin
    rst_n = 1'b0; arrive = 1'b0; car_moving = 1'b0; cur_floor = 2'd0;
    open_btn = 1'b0; close_btn = 1'b0; obstruct = 1'b0;
    #1;
    test_reset();
    test_normal_cycle();
    test_reset_mid_open();
    test_car_moving();
    test_close_btn();
    test_obstruct_reopen();
    test_obstruct_hold();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, limit 1000000 ns", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
